thor2025_rename_map_ckpt: RTL and testbench

Parametrised register rename map with a checkpoint ring, committed (architectural) map, and recovery. It sits between decode and the ROB. It translates source architectural registers to physical registers and records new destination mappings for up to NWPORT instructions per cycle. On branch miss it restores a checkpoint; on exception it flushes to the committed map. At commit it returns the superseded physical register for the free list.

---
 rtl/thor2025_rename_pkg.sv | 25 ++
 rtl/thor2025_rename_lane_fwd.sv | 26 ++
 rtl/thor2025_rename_map_ckpt.sv | 163 ++++++++++++++++
 tb/tb_thor2025_rename_map_ckpt.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thor2025_rename_pkg.sv
// Shared types and default sizing for the rename map, its checkpoint ring and
// the lane forwarder.
package thor2025_rename_pkg;

  localparam int NREG_DEF   = 64;
  localparam int NPREG_DEF  = 128;
  localparam int NCHECK_DEF = 8;
  localparam int NRPORT_DEF = 20;
  localparam int NWPORT_DEF = 2;
  localparam int NCMT_DEF   = 3;

  localparam int AREG_W = $clog2(NREG_DEF);
  localparam int PREG_W = $clog2(NPREG_DEF);
  localparam int CP_W   = $clog2(NCHECK_DEF);

  typedef logic [AREG_W-1:0] aregno_t;
  typedef logic [PREG_W-1:0] pregno_t;
  typedef logic [CP_W-1:0]   cpno_t;

  typedef struct packed {
    logic    v;
    pregno_t preg;
  } map_entry_t;

endpackage

// File: rtl/thor2025_rename_lane_fwd.sv
// N-lane same-index priority forwarder: each lane sees the table value at its
// index, overridden by the highest lower-numbered valid lane naming that index.
module thor2025_rename_lane_fwd #(
  parameter int N  = 2,
  parameter int IW = 6,
  parameter int VW = 7
) (
  input  logic [N-1:0]    vld_i,
  input  logic [N*IW-1:0] idx_i,
  input  logic [N*VW-1:0] val_i,
  input  logic [N*VW-1:0] base_i,
  output logic [N*VW-1:0] fwd_o
);

  always_comb begin
    fwd_o = base_i;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (i < j && vld_i[i] && idx_i[i*IW +: IW] == idx_i[j*IW +: IW]) begin
          fwd_o[j*VW +: VW] = val_i[i*VW +: VW];
        end
      end
    end
  end

endmodule

// File: rtl/thor2025_rename_map_ckpt.sv
// Register rename map with a checkpoint ring for branch recovery, a committed
// map for exception flush, and superseded-register return at commit.
module thor2025_rename_map_ckpt
  import thor2025_rename_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NPREG  = NPREG_DEF,
  parameter int NCHECK = NCHECK_DEF,
  parameter int NRPORT = NRPORT_DEF,
  parameter int NWPORT = NWPORT_DEF,
  parameter int NCMT   = NCMT_DEF,
  localparam int AW    = $clog2(NREG),
  localparam int PW    = $clog2(NPREG),
  localparam int CW    = $clog2(NCHECK)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRPORT*AW-1:0] rd_areg_i,
  output logic [NRPORT*PW-1:0] rd_preg_o,
  output logic [NRPORT-1:0]    rd_v_o,
  input  logic [NWPORT-1:0]    ren_v_i,
  input  logic [NWPORT*AW-1:0] ren_areg_i,
  input  logic [NWPORT*PW-1:0] ren_preg_i,
  output logic [NWPORT*PW-1:0] ren_old_preg_o,
  input  logic                 cp_req_i,
  output logic                 cp_ack_o,
  output logic [CW-1:0]        cp_id_o,
  output logic                 cp_full_o,
  input  logic                 cp_rel_i,
  input  logic                 bkout_v_i,
  input  logic [CW-1:0]        bkout_id_i,
  input  logic                 flush_i,
  input  logic [NCMT-1:0]      cmt_v_i,
  input  logic [NCMT*AW-1:0]   cmt_areg_i,
  input  logic [NCMT*PW-1:0]   cmt_preg_i,
  output logic [NCMT-1:0]      free_v_o,
  output logic [NCMT*PW-1:0]   free_preg_o
);

  localparam logic [CW:0] PTR_ONE = (CW+1)'(1);
  localparam logic [CW:0] PTR_MAX = (CW+1)'(NCHECK);

  map_entry_t cur_q  [NREG];
  map_entry_t cur_d  [NREG];
  map_entry_t cur_ren[NREG];
  map_entry_t arch_q [NREG];
  map_entry_t arch_d [NREG];
  map_entry_t ckpt_q [NCHECK][NREG];

  logic [CW:0]        head_q, head_d, tail_q, tail_d, count;
  logic [CW-1:0]      bk_off;
  logic               cp_full, cp_alloc, cp_rel_ok;
  logic [NWPORT*PW-1:0] ren_base;
  logic [NCMT*PW-1:0]   cmt_base, free_preg_d;
  logic [NCMT-1:0]      free_v_q;
  logic [NCMT*PW-1:0]   free_preg_q;

  always_comb begin
    for (int p = 0; p < NRPORT; p++) begin
      rd_preg_o[p*PW +: PW] = cur_q[rd_areg_i[p*AW +: AW]].preg;
      rd_v_o[p]             = cur_q[rd_areg_i[p*AW +: AW]].v;
    end
    for (int j = 0; j < NWPORT; j++) begin
      ren_base[j*PW +: PW] = cur_q[ren_areg_i[j*AW +: AW]].preg;
    end
    for (int k = 0; k < NCMT; k++) begin
      cmt_base[k*PW +: PW] = arch_q[cmt_areg_i[k*AW +: AW]].preg;
    end
  end

  thor2025_rename_lane_fwd #(.N(NWPORT), .IW(AW), .VW(PW)) u_ren_fwd (
    .vld_i  (ren_v_i),
    .idx_i  (ren_areg_i),
    .val_i  (ren_preg_i),
    .base_i (ren_base),
    .fwd_o  (ren_old_preg_o)
  );

  thor2025_rename_lane_fwd #(.N(NCMT), .IW(AW), .VW(PW)) u_cmt_fwd (
    .vld_i  (cmt_v_i),
    .idx_i  (cmt_areg_i),
    .val_i  (cmt_preg_i),
    .base_i (cmt_base),
    .fwd_o  (free_preg_d)
  );

  // Occupancy is judged on the pre-cycle count, so a same-cycle release at
  // full does not make room for an allocation.
  always_comb begin
    count     = tail_q - head_q;
    cp_full   = (count == PTR_MAX);
    cp_alloc  = cp_req_i && !cp_full && !flush_i && !bkout_v_i;
    cp_rel_ok = cp_rel_i && (count != '0);
    bk_off    = bkout_id_i - head_q[CW-1:0];

    cur_ren = cur_q;
    for (int j = 0; j < NWPORT; j++) begin
      if (ren_v_i[j]) begin
        cur_ren[ren_areg_i[j*AW +: AW]] = '{v: 1'b1, preg: ren_preg_i[j*PW +: PW]};
      end
    end

    arch_d = arch_q;
    for (int k = 0; k < NCMT; k++) begin
      if (cmt_v_i[k]) begin
        arch_d[cmt_areg_i[k*AW +: AW]] = '{v: 1'b1, preg: cmt_preg_i[k*PW +: PW]};
      end
    end

    cur_d  = cur_ren;
    head_d = cp_rel_ok ? head_q + PTR_ONE : head_q;
    tail_d = tail_q;
    if (flush_i) begin
      cur_d  = arch_q;
      head_d = '0;
      tail_d = '0;
    end else if (bkout_v_i) begin
      cur_d  = ckpt_q[bkout_id_i];
      tail_d = head_q + {1'b0, bk_off} + PTR_ONE;
    end else if (cp_alloc) begin
      tail_d = tail_q + PTR_ONE;
    end
  end

  assign cp_ack_o    = rst_n && cp_alloc;
  assign cp_id_o     = tail_q[CW-1:0];
  assign cp_full_o   = cp_full;
  assign free_v_o    = free_v_q;
  assign free_preg_o = free_preg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NREG; n++) begin
        cur_q[n]  <= '{v: 1'b1, preg: pregno_t'(n)};
        arch_q[n] <= '{v: 1'b1, preg: pregno_t'(n)};
      end
      head_q      <= '0;
      tail_q      <= '0;
      free_v_q    <= '0;
      free_preg_q <= '0;
    end else begin
      cur_q       <= cur_d;
      arch_q      <= arch_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      free_v_q    <= cmt_v_i;
      free_preg_q <= free_preg_d;
    end
  end

  // Snapshot storage needs no reset: a slot is only read after being written.
  always_ff @(posedge clk) begin
    if (cp_alloc) begin
      ckpt_q[tail_q[CW-1:0]] <= cur_ren;
    end
  end

  a_rel_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    cp_rel_i |-> (count != '0));
  a_bkout_live: assert property (@(posedge clk) disable iff (!rst_n)
    (bkout_v_i && !flush_i) |-> ({1'b0, bk_off} < count));

endmodule

// File: tb/tb_thor2025_rename_map_ckpt.sv
// Randomized and directed bench for the rename map against a queue-based
// behavioural model of maps, checkpoints and commits.
module tb_thor2025_rename_map_ckpt;
  import thor2025_rename_pkg::*;

  localparam int NREG = 64, NPREG = 128, NCHECK = 8;
  localparam int NRPORT = 20, NWPORT = 2, NCMT = 3;
  localparam int AW = 6, PW = 7, CW = 3;

  logic                 clk, rst_n;
  logic [NRPORT*AW-1:0] rd_areg;
  logic [NRPORT*PW-1:0] rd_preg;
  logic [NRPORT-1:0]    rd_v;
  logic [NWPORT-1:0]    ren_v;
  logic [NWPORT*AW-1:0] ren_areg;
  logic [NWPORT*PW-1:0] ren_preg;
  logic [NWPORT*PW-1:0] ren_old_preg;
  logic                 cp_req, cp_ack, cp_full, cp_rel, bkout_v, flush;
  logic [CW-1:0]        cp_id, bkout_id;
  logic [NCMT-1:0]      cmt_v, free_v;
  logic [NCMT*AW-1:0]   cmt_areg;
  logic [NCMT*PW-1:0]   cmt_preg, free_preg;

  thor2025_rename_map_ckpt #(
    .NREG(NREG), .NPREG(NPREG), .NCHECK(NCHECK),
    .NRPORT(NRPORT), .NWPORT(NWPORT), .NCMT(NCMT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_areg_i(rd_areg), .rd_preg_o(rd_preg), .rd_v_o(rd_v),
    .ren_v_i(ren_v), .ren_areg_i(ren_areg), .ren_preg_i(ren_preg),
    .ren_old_preg_o(ren_old_preg),
    .cp_req_i(cp_req), .cp_ack_o(cp_ack), .cp_id_o(cp_id), .cp_full_o(cp_full),
    .cp_rel_i(cp_rel), .bkout_v_i(bkout_v), .bkout_id_i(bkout_id), .flush_i(flush),
    .cmt_v_i(cmt_v), .cmt_areg_i(cmt_areg), .cmt_preg_i(cmt_preg),
    .free_v_o(free_v), .free_preg_o(free_preg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: maps as int arrays, live checkpoints as a queue of slot ids.
  int m_cur[NREG];
  int m_arch[NREG];
  int m_ckpt[NCHECK][NREG];
  int m_q[$];
  int m_tail;
  logic [NCMT-1:0] m_free_v;
  int m_free[NCMT];
  int n_cmp, n_err;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int n = 0; n < NREG; n++) begin
      m_cur[n]  = n;
      m_arch[n] = n;
    end
    m_q.delete();
    m_tail   = 0;
    m_free_v = '0;
    for (int k = 0; k < NCMT; k++) m_free[k] = 0;
  endtask

  task automatic clear_ctl();
    ren_v = '0; ren_areg = '0; ren_preg = '0;
    cp_req = 1'b0; cp_rel = 1'b0; bkout_v = 1'b0; bkout_id = '0; flush = 1'b0;
    cmt_v = '0; cmt_areg = '0; cmt_preg = '0;
    for (int p = 0; p < NRPORT; p++) rd_areg[p*AW +: AW] = AW'(p);
  endtask

  task automatic probe();
    #1;
    for (int p = 0; p < NRPORT; p++) begin
      chk_val($sformatf("rd_preg%0d", p), 32'(rd_preg[p*PW +: PW]), m_cur[rd_areg[p*AW +: AW]]);
      chk_val($sformatf("rd_v%0d", p), 32'(rd_v[p]), 1);
    end
    for (int j = 0; j < NWPORT; j++) begin
      int e;
      e = m_cur[ren_areg[j*AW +: AW]];
      for (int i = 0; i < j; i++)
        if (ren_v[i] && ren_areg[i*AW +: AW] == ren_areg[j*AW +: AW]) e = ren_preg[i*PW +: PW];
      chk_val($sformatf("ren_old%0d", j), 32'(ren_old_preg[j*PW +: PW]), e);
    end
    chk_val("cp_ack", 32'(cp_ack),
            32'(cp_req && m_q.size() < NCHECK && !flush && !bkout_v));
    chk_val("cp_id", 32'(cp_id), m_tail);
    chk_val("cp_full", 32'(cp_full), 32'(m_q.size() == NCHECK));
    for (int k = 0; k < NCMT; k++) begin
      chk_val($sformatf("free_v%0d", k), 32'(free_v[k]), 32'(m_free_v[k]));
      if (m_free_v[k]) chk_val($sformatf("free_preg%0d", k), 32'(free_preg[k*PW +: PW]), m_free[k]);
    end
  endtask

  task automatic step();
    int ren_map[NREG];
    int arch_new[NREG];
    int pre;
    bit ack;
    @(posedge clk);
    pre = m_q.size();
    ack = cp_req && pre < NCHECK && !flush && !bkout_v;
    ren_map = m_cur;
    for (int j = 0; j < NWPORT; j++)
      if (ren_v[j]) ren_map[ren_areg[j*AW +: AW]] = ren_preg[j*PW +: PW];
    arch_new = m_arch;
    for (int k = 0; k < NCMT; k++) begin
      m_free_v[k] = cmt_v[k];
      m_free[k]   = arch_new[cmt_areg[k*AW +: AW]];
      if (cmt_v[k]) arch_new[cmt_areg[k*AW +: AW]] = cmt_preg[k*PW +: PW];
    end
    if (flush) begin
      m_cur = m_arch;
      m_q.delete();
      m_tail = 0;
    end else if (bkout_v) begin
      m_cur = m_ckpt[bkout_id];
      while (m_q.size() > 0 && m_q[m_q.size()-1] != int'(bkout_id)) void'(m_q.pop_back());
      m_tail = (int'(bkout_id) + 1) % NCHECK;
      if (cp_rel && m_q.size() > 0) void'(m_q.pop_front());
    end else begin
      m_cur = ren_map;
      if (ack) begin
        m_ckpt[m_tail] = ren_map;
        m_q.push_back(m_tail);
        m_tail = (m_tail + 1) % NCHECK;
      end
      if (cp_rel && pre > 0) void'(m_q.pop_front());
    end
    m_arch = arch_new;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < NRPORT; p++) rd_areg[p*AW +: AW] = AW'($urandom_range(0, NREG-1));
    ren_v = NWPORT'($urandom);
    for (int j = 0; j < NWPORT; j++) begin
      ren_areg[j*AW +: AW] = AW'($urandom_range(0, 15));
      ren_preg[j*PW +: PW] = PW'($urandom_range(0, NPREG-1));
    end
    cp_req  = 1'($urandom_range(0, 1));
    cp_rel  = (m_q.size() > 0) && ($urandom_range(0, 3) == 0);
    bkout_v = 1'b0;
    bkout_id = '0;
    if (m_q.size() > 0 && $urandom_range(0, 11) == 0) begin
      bkout_v  = 1'b1;
      bkout_id = CW'(m_q[$urandom_range(0, m_q.size()-1)]);
    end
    flush = ($urandom_range(0, 39) == 0);
    cmt_v = NCMT'($urandom);
    for (int k = 0; k < NCMT; k++) begin
      cmt_areg[k*AW +: AW] = AW'($urandom_range(0, 15));
      cmt_preg[k*PW +: PW] = PW'($urandom_range(0, NPREG-1));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_ctl();
    rd_areg[0 +: AW] = AW'(5);
    cp_req = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_val("rst_rd5", 32'(rd_preg[0 +: PW]), 5);
    chk_val("rst_rd_v", 32'(rd_v[0]), 1);
    chk_val("rst_cp_ack", 32'(cp_ack), 0);
    chk_val("rst_cp_full", 32'(cp_full), 0);
    chk_val("rst_cp_id", 32'(cp_id), 0);
    chk_val("rst_free_v", 32'(free_v), 0);
    chk_val("rst_free_preg", 32'(free_preg), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Commit r5 -> p70 returns p5
    clear_ctl(); cmt_v = 3'b001; cmt_areg[0 +: AW] = 6'd5; cmt_preg[0 +: PW] = 7'd70;
    probe(); step();
    clear_ctl(); probe();
    chk_val("d_free_v0", 32'(free_v[0]), 1);
    chk_val("d_free_p0", 32'(free_preg[0 +: PW]), 5);
    step();

    // Two lanes renaming r3
    clear_ctl(); ren_v = 2'b11;
    ren_areg = {6'd3, 6'd3}; ren_preg = {7'd81, 7'd80};
    probe();
    chk_val("d_old0", 32'(ren_old_preg[0 +: PW]), 3);
    chk_val("d_old1", 32'(ren_old_preg[PW +: PW]), 80);
    step();
    clear_ctl(); rd_areg[0 +: AW] = 6'd3; probe();
    chk_val("d_r3", 32'(rd_preg[0 +: PW]), 81);
    step();

    // Checkpoint then backout
    clear_ctl(); cp_req = 1'b1; ren_v = 2'b01; ren_areg[0 +: AW] = 6'd7; ren_preg[0 +: PW] = 7'd90;
    probe();
    chk_val("d_cp_ack", 32'(cp_ack), 1);
    chk_val("d_cp_id0", 32'(cp_id), 0);
    step();
    clear_ctl(); ren_v = 2'b01; ren_areg[0 +: AW] = 6'd7; ren_preg[0 +: PW] = 7'd91;
    probe(); step();
    clear_ctl(); bkout_v = 1'b1; bkout_id = 3'd0; probe(); step();
    clear_ctl(); rd_areg[0 +: AW] = 6'd7; probe();
    chk_val("d_r7", 32'(rd_preg[0 +: PW]), 90);
    chk_val("d_cnt1_id", 32'(cp_id), 1);
    step();

    // Fill ring, then release+request at full
    for (int i = 0; i < 7; i++) begin
      clear_ctl(); cp_req = 1'b1; probe(); step();
    end
    clear_ctl(); probe();
    chk_val("d_full", 32'(cp_full), 1);
    cp_req = 1'b1; cp_rel = 1'b1; probe();
    chk_val("d_full_ack", 32'(cp_ack), 0);
    step();
    clear_ctl(); probe();
    chk_val("d_cnt7_full", 32'(cp_full), 0);
    step();

    // Commit, rename, then flush with a concurrent backout
    clear_ctl(); cmt_v = 3'b001; cmt_areg[0 +: AW] = 6'd2; cmt_preg[0 +: PW] = 7'd100;
    probe(); step();
    clear_ctl(); ren_v = 2'b01; ren_areg[0 +: AW] = 6'd2; ren_preg[0 +: PW] = 7'd101;
    probe(); step();
    clear_ctl(); flush = 1'b1; bkout_v = 1'b1; bkout_id = 3'd3; probe(); step();
    clear_ctl(); rd_areg[0 +: AW] = 6'd2; probe();
    chk_val("d_r2", 32'(rd_preg[0 +: PW]), 100);
    chk_val("d_flush_id", 32'(cp_id), 0);
    chk_val("d_flush_full", 32'(cp_full), 0);
    step();

    // Two commit lanes to r9
    clear_ctl(); cmt_v = 3'b011;
    cmt_areg[0 +: AW] = 6'd9; cmt_areg[AW +: AW] = 6'd9;
    cmt_preg[0 +: PW] = 7'd110; cmt_preg[PW +: PW] = 7'd111;
    probe(); step();
    clear_ctl(); flush = 1'b1; probe();
    chk_val("d_free9_0", 32'(free_preg[0 +: PW]), 9);
    chk_val("d_free9_1", 32'(free_preg[PW +: PW]), 110);
    chk_val("d_free9_v", 32'(free_v), 3);
    step();
    clear_ctl(); rd_areg[0 +: AW] = 6'd9; probe();
    chk_val("d_r9", 32'(rd_preg[0 +: PW]), 111);
    step();

    repeat (600) begin
      rand_inputs(); probe(); step();
    end

    // Asynchronous reset in mid-operation
    rand_inputs();
    cp_req = 1'b1; bkout_v = 1'b0; flush = 1'b0;
    #3 rst_n = 1'b0;
    m_reset();
    #1;
    chk_val("mr_cp_ack", 32'(cp_ack), 0);
    chk_val("mr_cp_full", 32'(cp_full), 0);
    chk_val("mr_cp_id", 32'(cp_id), 0);
    chk_val("mr_free_v", 32'(free_v), 0);
    chk_val("mr_free_preg", 32'(free_preg), 0);
    for (int p = 0; p < NRPORT; p++)
      chk_val($sformatf("mr_rd%0d", p), 32'(rd_preg[p*PW +: PW]), 32'(rd_areg[p*AW +: AW]));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      rand_inputs(); probe(); step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
